// File: rtl/id_ex_stage_if.sv
// Bundles the ID-side inputs, MEM writeback snoop, and registered EX-side outputs of id_ex_stage.
// Latency: n/a (wiring only).
// Backpressure: stall is driven by the stage back toward IF/ID; there is no downstream ready.
// Port summary:
//   master modport (upstream/downstream driver): drives id_*, flush, mem_wr_*;
//                                                 receives stall, ex_*, bubble_cnt
//   slave modport (id_ex_stage): the mirror image
interface id_ex_stage_if #(parameter int DATA_W = 32);
  logic              id_valid;
  logic [DATA_W-1:0] id_pc;
  logic [3:0]        id_aluop;
  logic              id_dmload, id_dmstr, id_dmsel;
  logic [4:0]        id_ra, id_rb;
  logic              id_use_a, id_use_b;
  logic              id_wr_en;
  logic [4:0]        id_wr_reg;
  logic [15:0]       id_imm;
  logic [DATA_W-1:0] id_a, id_b;
  logic              flush;
  logic              mem_wr_en;
  logic [4:0]        mem_wr_reg;
  logic              stall;
  logic              ex_valid, ex_dmload, ex_dmstr, ex_dmsel, ex_wr_en;
  logic [3:0]        ex_aluop;
  logic [4:0]        ex_wr_reg, ex_ra, ex_rb;
  logic [15:0]       ex_imm;
  logic [DATA_W-1:0] ex_pc, ex_a, ex_b;
  logic [1:0]        ex_fwd_a, ex_fwd_b;
  logic [15:0]       bubble_cnt;

  modport master (
    output id_valid, id_pc, id_aluop, id_dmload, id_dmstr, id_dmsel, id_ra, id_rb,
           id_use_a, id_use_b, id_wr_en, id_wr_reg, id_imm, id_a, id_b,
           flush, mem_wr_en, mem_wr_reg,
    input  stall, ex_valid, ex_dmload, ex_dmstr, ex_dmsel, ex_wr_en, ex_aluop,
           ex_wr_reg, ex_ra, ex_rb, ex_imm, ex_pc, ex_a, ex_b, ex_fwd_a, ex_fwd_b,
           bubble_cnt
  );

  modport slave (
    input  id_valid, id_pc, id_aluop, id_dmload, id_dmstr, id_dmsel, id_ra, id_rb,
           id_use_a, id_use_b, id_wr_en, id_wr_reg, id_imm, id_a, id_b,
           flush, mem_wr_en, mem_wr_reg,
    output stall, ex_valid, ex_dmload, ex_dmstr, ex_dmsel, ex_wr_en, ex_aluop,
           ex_wr_reg, ex_ra, ex_rb, ex_imm, ex_pc, ex_a, ex_b, ex_fwd_a, ex_fwd_b,
           bubble_cnt
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use / RAW hazard detection and forwarding selects.
// Latency: one cycle from ID fields to ex_*; stall is combinational in the ID cycle.
// Backpressure: stall holds PC and IF/ID while a bubble is loaded; flush overrides stall.
// Ports: clk, rst (async active-high), bus (id_ex_stage_if.slave).
// Build option: REDIRECT_EN defined -> forwarding enabled, only load-use stalls;
//               undefined -> any live EX/MEM hazard stalls, ex_fwd_* tied to 00.
module id_ex_stage #(
  parameter int DATA_W = 32
) (
  input logic          clk,
  input logic          rst,
  id_ex_stage_if.slave bus
);

  typedef struct packed {
    logic              valid;
    logic              dmload;
    logic              dmstr;
    logic              dmsel;
    logic              wr_en;
    logic [3:0]        aluop;
    logic [4:0]        wr_reg;
    logic [4:0]        ra;
    logic [4:0]        rb;
    logic [15:0]       imm;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
  } ex_t;

  ex_t         ex_q, ex_d;
  logic [15:0] bubble_q;

  logic live_a, live_b;
  logic ex_haz_a, ex_haz_b;
  logic mem_haz_a, mem_haz_b;
  logic hazard_stall;
  logic stall_int;
  logic [1:0] fwd_a, fwd_b;

  // r0 is hardwired, so it never carries a dependence.
  assign live_a = bus.id_valid & bus.id_use_a & (bus.id_ra != 5'd0);
  assign live_b = bus.id_valid & bus.id_use_b & (bus.id_rb != 5'd0);

  assign ex_haz_a  = live_a & ex_q.valid & ex_q.wr_en & (ex_q.wr_reg == bus.id_ra);
  assign ex_haz_b  = live_b & ex_q.valid & ex_q.wr_en & (ex_q.wr_reg == bus.id_rb);
  assign mem_haz_a = live_a & bus.mem_wr_en & (bus.mem_wr_reg == bus.id_ra);
  assign mem_haz_b = live_b & bus.mem_wr_en & (bus.mem_wr_reg == bus.id_rb);

`ifdef REDIRECT_EN
  // A load's data is not available until it leaves MEM, so only that case waits.
  assign hazard_stall = (ex_haz_a | ex_haz_b) & ex_q.dmload;
  // The EX producer will sit in MEM next cycle, which is the younger (correct) value.
  assign fwd_a = ex_haz_a ? 2'b01 : (mem_haz_a ? 2'b10 : 2'b00);
  assign fwd_b = ex_haz_b ? 2'b01 : (mem_haz_b ? 2'b10 : 2'b00);
`else
  // No bypass paths: wait until the producer has reached WB (regfile writes first).
  assign hazard_stall = ex_haz_a | ex_haz_b | mem_haz_a | mem_haz_b;
  assign fwd_a = 2'b00;
  assign fwd_b = 2'b00;
`endif

  assign stall_int = ~bus.flush & hazard_stall;

  always_comb begin
    ex_d = '0;
    if (!(bus.flush || stall_int)) begin
      ex_d.valid  = bus.id_valid;
      ex_d.dmload = bus.id_dmload;
      ex_d.dmstr  = bus.id_dmstr;
      ex_d.dmsel  = bus.id_dmsel;
      ex_d.wr_en  = bus.id_wr_en;
      ex_d.aluop  = bus.id_aluop;
      ex_d.wr_reg = bus.id_wr_reg;
      ex_d.ra     = bus.id_ra;
      ex_d.rb     = bus.id_rb;
      ex_d.imm    = bus.id_imm;
      ex_d.pc     = bus.id_pc;
      ex_d.a      = bus.id_a;
      ex_d.b      = bus.id_b;
      ex_d.fwd_a  = fwd_a;
      ex_d.fwd_b  = fwd_b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_q <= '0;
    end else if (stall_int && (bubble_q != 16'hFFFF)) begin
      bubble_q <= bubble_q + 16'd1;
    end
  end

  assign bus.stall      = stall_int;
  assign bus.ex_valid   = ex_q.valid;
  assign bus.ex_dmload  = ex_q.dmload;
  assign bus.ex_dmstr   = ex_q.dmstr;
  assign bus.ex_dmsel   = ex_q.dmsel;
  assign bus.ex_wr_en   = ex_q.wr_en;
  assign bus.ex_aluop   = ex_q.aluop;
  assign bus.ex_wr_reg  = ex_q.wr_reg;
  assign bus.ex_ra      = ex_q.ra;
  assign bus.ex_rb      = ex_q.rb;
  assign bus.ex_imm     = ex_q.imm;
  assign bus.ex_pc      = ex_q.pc;
  assign bus.ex_a       = ex_q.a;
  assign bus.ex_b       = ex_q.b;
  assign bus.ex_fwd_a   = ex_q.fwd_a;
  assign bus.ex_fwd_b   = ex_q.fwd_b;
  assign bus.bubble_cnt = bubble_q;

endmodule
